// File: rtl/fruta_pkg.sv
// fruta_pkg: shared definitions for the fruit-position generator.
// Map cell codes, FSM state encoding, LFSR taps/seed and the LFSR step function.
package fruta_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'd0;
   localparam logic [1:0] CELL_SNAKE = 2'd1;
   localparam logic [1:0] CELL_FRUIT = 2'd2;
   localparam logic [1:0] CELL_OBST  = 2'd3;

   // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
   localparam logic [15:0] LFSR_TAPS         = 16'h002D;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   typedef enum logic [2:0] {
      IDLE,
      DRAW,
      READ,
      CHECK,
      SCAN_READ,
      SCAN_CHECK,
      DONE
   } fruta_state_e;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {^(v & LFSR_TAPS), v[15:1]};
   endfunction

endpackage

// File: rtl/fruta_lfsr.sv
// fruta_lfsr: seedable 16-bit free-running Fibonacci LFSR, synchronous reset to SEED.
module fruta_lfsr
   import fruta_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
)(
   input  logic        i_clk,
   input  logic        i_reset,
   output logic [15:0] o_lfsr
);

   logic [15:0] r_lfsr;

   // Free-running shift register; advances every cycle outside reset
   always_ff @(posedge i_clk) begin
      if (i_reset) r_lfsr <= SEED;
      else         r_lfsr <= lfsr_next(r_lfsr);
   end

   assign o_lfsr = r_lfsr;

endmodule

// File: rtl/fruta_gen.sv
// fruta_gen: fruit-position generator. Draws random map cells from an LFSR,
// probes the map through a read port, and after MAX_TRIES occupied hits falls
// back to a raster scan. Optional macro FRUTA_AVOID_BORDER_EN restricts
// results to interior cells (border cells are never drawn or read).
module fruta_gen
   import fruta_pkg::*;
#(
   parameter int unsigned MAPA_WIDTH  = 40,
   parameter int unsigned MAPA_HEIGHT = 30,
   parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED,
   parameter int unsigned MAX_TRIES   = 16
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       fruta_enable,
   output logic       fruta_wenable,
   output logic [9:0] fruta_wx,
   output logic [9:0] fruta_wy,
   output logic       fruta_fail,
   output logic       busy,
   output logic       gen_renable,
   output logic [9:0] gen_rx,
   output logic [9:0] gen_ry,
   input  logic [1:0] gen_rdata
);

   localparam int unsigned XB = $clog2(MAPA_WIDTH);
   localparam int unsigned YB = $clog2(MAPA_HEIGHT);
   localparam logic [9:0]  X_LAST = 10'(MAPA_WIDTH - 1);
   localparam logic [9:0]  Y_LAST = 10'(MAPA_HEIGHT - 1);
`ifdef FRUTA_AVOID_BORDER_EN
   localparam int unsigned SCAN_LIMIT = (MAPA_WIDTH - 2) * (MAPA_HEIGHT - 2);
`else
   localparam int unsigned SCAN_LIMIT = MAPA_WIDTH * MAPA_HEIGHT;
`endif
   localparam int unsigned SCW = $clog2(SCAN_LIMIT + 1);
   localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_LIMIT - 1);
   localparam int unsigned TW = $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES - 1);

   fruta_state_e r_state, w_state_next;

   logic [15:0]    w_lfsr;
   logic           w_unused_lfsr;
   logic [9:0]     w_cand_x, w_cand_y;
   logic           w_cand_ok;
   logic [9:0]     w_cand_nx, w_cand_ny;
   logic [9:0]     w_scan_nx, w_scan_ny;
   logic           w_scan_border;
   logic           w_empty;

   logic [9:0]     r_cand_x, r_cand_y;
   logic [9:0]     r_scan_x, r_scan_y;
   logic [SCW-1:0] r_scan_cnt;
   logic [TW-1:0]  r_tries;
   logic [9:0]     r_wx, r_wy;
   logic           r_fail;

   fruta_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .i_clk   (clk),
      .i_reset (reset),
      .o_lfsr  (w_lfsr)
   );

   function automatic logic [19:0] raster_next(input logic [9:0] x, input logic [9:0] y);
      logic [9:0] nx;
      logic [9:0] ny;
      if (x == X_LAST) begin
         nx = '0;
         ny = (y == Y_LAST) ? '0 : y + 10'd1;
      end else begin
         nx = x + 10'd1;
         ny = y;
      end
      return {nx, ny};
   endfunction

   assign w_cand_x      = 10'(w_lfsr[XB-1:0]);
   assign w_cand_y      = 10'(w_lfsr[XB+YB-1:XB]);
   assign w_unused_lfsr = ^w_lfsr[15:XB+YB];
   assign w_empty       = (gen_rdata == CELL_EMPTY);
   assign {w_cand_nx, w_cand_ny} = raster_next(r_cand_x, r_cand_y);
   assign {w_scan_nx, w_scan_ny} = raster_next(r_scan_x, r_scan_y);

`ifdef FRUTA_AVOID_BORDER_EN
   assign w_cand_ok = (w_cand_x >= 10'd1) && (w_cand_x < X_LAST) &&
                      (w_cand_y >= 10'd1) && (w_cand_y < Y_LAST);
   assign w_scan_border = (r_scan_x == '0) || (r_scan_x == X_LAST) ||
                          (r_scan_y == '0) || (r_scan_y == Y_LAST);
`else
   assign w_cand_ok     = (w_cand_x <= X_LAST) && (w_cand_y <= Y_LAST);
   assign w_scan_border = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:       if (fruta_enable) w_state_next = DRAW;
         DRAW:       if (w_cand_ok) w_state_next = READ;
         READ:       w_state_next = CHECK;
         CHECK: begin
            if (w_empty)                    w_state_next = DONE;
            else if (r_tries == TRIES_LAST) w_state_next = SCAN_READ;
            else                            w_state_next = DRAW;
         end
         SCAN_READ:  if (!w_scan_border) w_state_next = SCAN_CHECK;
         SCAN_CHECK: begin
            if (w_empty)                        w_state_next = DONE;
            else if (r_scan_cnt == SCAN_LAST)   w_state_next = IDLE;
            else                                w_state_next = SCAN_READ;
         end
         DONE:       w_state_next = IDLE;
         default:    w_state_next = IDLE;
      endcase
   end

   // Datapath: candidate, retry/scan counters, result and fail strobe.
   // The result is captured on entry to DONE so it is valid alongside the strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cand_x   <= '0;
         r_cand_y   <= '0;
         r_scan_x   <= '0;
         r_scan_y   <= '0;
         r_scan_cnt <= '0;
         r_tries    <= '0;
         r_wx       <= '0;
         r_wy       <= '0;
         r_fail     <= 1'b0;
      end else begin
         r_fail <= (r_state == SCAN_CHECK) && !w_empty && (r_scan_cnt == SCAN_LAST);
         case (r_state)
            IDLE: if (fruta_enable) r_tries <= '0;
            DRAW: begin
               if (w_cand_ok) begin
                  r_cand_x <= w_cand_x;
                  r_cand_y <= w_cand_y;
               end
            end
            CHECK: begin
               if (w_empty) begin
                  r_wx <= r_cand_x;
                  r_wy <= r_cand_y;
               end else if (r_tries == TRIES_LAST) begin
                  r_scan_cnt <= '0;
                  r_scan_x   <= w_cand_nx;
                  r_scan_y   <= w_cand_ny;
               end else begin
                  r_tries <= r_tries + 1'b1;
               end
            end
            SCAN_READ: begin
               if (w_scan_border) begin
                  r_scan_x <= w_scan_nx;
                  r_scan_y <= w_scan_ny;
               end
            end
            SCAN_CHECK: begin
               if (w_empty) begin
                  r_wx <= r_scan_x;
                  r_wy <= r_scan_y;
               end else begin
                  r_scan_cnt <= r_scan_cnt + 1'b1;
                  r_scan_x   <= w_scan_nx;
                  r_scan_y   <= w_scan_ny;
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode from the current state
   always_comb begin
      gen_renable   = 1'b0;
      gen_rx        = '0;
      gen_ry        = '0;
      fruta_wenable = 1'b0;
      busy          = 1'b0;
      case (r_state)
         DRAW, CHECK, SCAN_CHECK: busy = 1'b1;
         READ: begin
            busy        = 1'b1;
            gen_renable = 1'b1;
            gen_rx      = r_cand_x;
            gen_ry      = r_cand_y;
         end
         SCAN_READ: begin
            busy = 1'b1;
            if (!w_scan_border) begin
               gen_renable = 1'b1;
               gen_rx      = r_scan_x;
               gen_ry      = r_scan_y;
            end
         end
         DONE:    fruta_wenable = 1'b1;
         default: ;
      endcase
   end

   assign fruta_wx   = r_wx;
   assign fruta_wy   = r_wy;
   assign fruta_fail = r_fail;

endmodule

// File: tb/tb_fruta_gen.sv
// tb_fruta_gen: randomized self-checking bench for fruta_gen with a map memory
// model and a procedural reference that predicts every read and result cycle.
`timescale 1ns/1ps
module tb_fruta_gen;

   localparam int W   = 40;
   localparam int H   = 30;
   localparam int MT  = 4;
   localparam int XB  = $clog2(W);
   localparam int YB  = $clog2(H);
   localparam int LFN = 32768;
`ifdef FRUTA_AVOID_BORDER_EN
   localparam int SCAN_N = (W - 2) * (H - 2);
   localparam int NREQ   = 1000;
`else
   localparam int SCAN_N = W * H;
   localparam int NREQ   = 40;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       fruta_enable = 1'b0;
   logic       fruta_wenable, fruta_fail, busy, gen_renable;
   logic [9:0] fruta_wx, fruta_wy, gen_rx, gen_ry;
   logic [1:0] gen_rdata = 2'd0;

   logic [1:0]  map [0:W-1][0:H-1];
   logic [15:0] lf  [0:LFN-1];

   typedef struct { int cyc; int x; int y; } rd_t;
   rd_t exp_rd[$];
   int  rd_i, exp_end, exp_x, exp_y, last_x, last_y, req_t;
   bit  exp_ok;
   int  cyc = 0;
   int  total = 0, bad = 0;
   int  n_reads = 0, n_strobes = 0;
   int  seq_a[$];
   int  gaps[8];

   fruta_gen #(
      .MAPA_WIDTH  (W),
      .MAPA_HEIGHT (H),
      .LFSR_SEED   (16'hACE1),
      .MAX_TRIES   (MT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .fruta_enable  (fruta_enable),
      .fruta_wenable (fruta_wenable),
      .fruta_wx      (fruta_wx),
      .fruta_wy      (fruta_wy),
      .fruta_fail    (fruta_fail),
      .busy          (busy),
      .gen_renable   (gen_renable),
      .gen_rx        (gen_rx),
      .gen_ry        (gen_ry),
      .gen_rdata     (gen_rdata)
   );

   always #5 clk = ~clk;

   // cycle index since the last reset edge; equals the LFSR step count
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

   // map memory: registered read, data valid the cycle after the request
   always @(posedge clk)
      if (gen_renable)
         gen_rdata <= (gen_rx < W && gen_ry < H) ? map[gen_rx][gen_ry] : 2'd3;

   always @(negedge clk) begin
      if (gen_renable)   n_reads++;
      if (fruta_wenable) n_strobes++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic fb;
      fb = v[0] ^ v[2] ^ v[3] ^ v[5];
      return (v >> 1) | (16'(fb) << 15);
   endfunction

   function automatic bit eligible(input int x, input int y);
`ifdef FRUTA_AVOID_BORDER_EN
      return x >= 1 && x <= W - 2 && y >= 1 && y <= H - 2;
`else
      return x < W && y < H;
`endif
   endfunction

   function automatic bit on_border(input int x, input int y);
`ifdef FRUTA_AVOID_BORDER_EN
      return x == 0 || x == W - 1 || y == 0 || y == H - 1;
`else
      return (x < 0) || (y < 0);
`endif
   endfunction

   task automatic guard(input int t);
      if (t >= LFN - 8) begin
         $display("FAIL model: cycle index %0d beyond reference table", t);
         $fatal(1);
      end
   endtask

   task automatic fill_map(input bit full);
      for (int x = 0; x < W; x++)
         for (int y = 0; y < H; y++)
            map[x][y] = full ? 2'($urandom_range(1, 3)) : 2'd0;
   endtask

   // Reference: walk the generator's rules forward from the request cycle
   task automatic predict(input int t0);
      int t, tries, x, y, n;
      exp_rd.delete();
      rd_i = 0; t = t0 + 1; tries = 0; x = 0; y = 0;
      forever begin
         guard(t);
         x = int'(lf[t]) % (1 << XB);
         y = (int'(lf[t]) >> XB) % (1 << YB);
         if (eligible(x, y)) begin
            exp_rd.push_back('{t + 1, x, y});
            if (map[x][y] == 2'd0) begin
               exp_ok = 1'b1; exp_x = x; exp_y = y; exp_end = t + 3;
               return;
            end
            tries++;
            if (tries == MT) break;
            t += 3;
         end else begin
            t++;
         end
      end
      t += 3;
      n = 0;
      while (n < SCAN_N) begin
         x++;
         if (x == W) begin
            x = 0; y++;
            if (y == H) y = 0;
         end
         if (on_border(x, y)) begin
            t++;
            continue;
         end
         exp_rd.push_back('{t, x, y});
         if (map[x][y] == 2'd0) begin
            exp_ok = 1'b1; exp_x = x; exp_y = y; exp_end = t + 2;
            return;
         end
         n++;
         t += 2;
      end
      exp_ok = 1'b0;
      exp_end = t;
   endtask

   task automatic check_cycle(input int k);
      bit er;
      int ex, ey;
      logic [3:0] ev;
      er = 1'b0; ex = 0; ey = 0;
      if (rd_i < exp_rd.size() && exp_rd[rd_i].cyc == k) begin
         er = 1'b1; ex = exp_rd[rd_i].x; ey = exp_rd[rd_i].y; rd_i++;
      end
      ev = {er, (k == exp_end) && exp_ok, (k == exp_end) && !exp_ok, k < exp_end};
      chk("ctl{ren,wen,fail,busy}", {28'd0, gen_renable, fruta_wenable, fruta_fail, busy}, {28'd0, ev});
      if (er) chk("read_addr", {12'd0, gen_rx, gen_ry}, (ex << 10) | ey);
      if (k == exp_end) begin
         if (exp_ok) begin last_x = exp_x; last_y = exp_y; end
         chk("result_xy", {12'd0, fruta_wx, fruta_wy}, (last_x << 10) | last_y);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("idle", {28'd0, gen_renable, fruta_wenable, fruta_fail, busy}, 32'd0);
      end
   endtask

   // Issue a request in the current IDLE cycle and check every cycle to its end
   task automatic run_req(input bit hold);
      req_t = cyc;
      chk("lfsr", {16'd0, dut.u_lfsr.o_lfsr}, {16'd0, lf[req_t]});
      fruta_enable = 1'b1;
      predict(req_t);
      for (int k = req_t + 1; k <= exp_end; k++) begin
         @(negedge clk);
         if (!hold) fruta_enable = 1'b0;
         check_cycle(k);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      fruta_enable = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {6'd0, fruta_wenable, fruta_fail, busy, gen_renable,
                            fruta_wx, fruta_wy, gen_rx, gen_ry}, 32'd0);
      chk("reset_lfsr", {16'd0, dut.u_lfsr.o_lfsr}, 32'h0000ACE1);
      reset = 1'b0;
      last_x = 0;
      last_y = 0;
   endtask

   initial begin
      int s, prev, n0, acc, t0;
      lf[0] = 16'hACE1;
      for (int i = 1; i < LFN; i++) lf[i] = lfsr_step(lf[i - 1]);

      // reset state
      fill_map(1'b0);
      do_reset();

      // empty map: best-case latency and result equals the read address
      repeat (6) begin
         idle($urandom_range(1, 4));
         run_req(1'b0);
      end

      // single free cell: random tries exhausted, scan finds it
      fill_map(1'b1);
      map[7][5] = 2'd0;
      idle(2);
      run_req(1'b0);
      chk("single_free_cell", {12'd0, fruta_wx, fruta_wy}, (7 << 10) | 5);

      // full map: fail after MT random reads plus a full scan
      fill_map(1'b1);
      prev = (last_x << 10) | last_y;
      idle(2);
      n0 = n_reads;
      run_req(1'b0);
      idle(1);
      chk("full_map_reads", n_reads - n0, MT + SCAN_N);
      chk("full_map_hold_xy", {12'd0, fruta_wx, fruta_wy}, prev);

      // request held high: one result per acceptance, none queued
      fill_map(1'b0);
      idle(2);
      n0 = n_strobes;
      acc = 0;
      t0 = cyc;
      do begin
         run_req(1'b1);
         acc++;
         @(negedge clk);
      end while (cyc - t0 < 20);
      fruta_enable = 1'b0;
      idle(3);
      chk("held_request_results", n_strobes - n0, acc);

      // reset during SCAN_READ aborts without a strobe
      fill_map(1'b1);
      idle(2);
      req_t = cyc;
      fruta_enable = 1'b1;
      predict(req_t);
      s = exp_rd[MT].cyc;
      for (int k = req_t + 1; k <= s; k++) begin
         @(negedge clk);
         fruta_enable = 1'b0;
         check_cycle(k);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("abort{busy,ren,wen,fail}", {28'd0, busy, gen_renable, fruta_wenable, fruta_fail}, 32'd0);
      reset = 1'b0;
      last_x = 0;
      last_y = 0;
      idle(3);

      // determinism: same seed and timing gives the same sequence
      fill_map(1'b0);
      foreach (gaps[i]) gaps[i] = $urandom_range(1, 5);
      do_reset();
      foreach (gaps[i]) begin
         idle(gaps[i]);
         run_req(1'b0);
         seq_a.push_back((exp_x << 10) | exp_y);
      end
      do_reset();
      foreach (gaps[i]) begin
         idle(gaps[i]);
         run_req(1'b0);
         chk("repeat_sequence", {12'd0, fruta_wx, fruta_wy}, seq_a[i]);
      end

      // eligibility bounds over many requests
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         idle($urandom_range(1, 3));
         run_req(1'b0);
`ifdef FRUTA_AVOID_BORDER_EN
         chk("interior_only", {31'd0, fruta_wx >= 1 && fruta_wx <= W - 2 &&
                                      fruta_wy >= 1 && fruta_wy <= H - 2}, 32'd1);
`else
         chk("in_map", {31'd0, fruta_wx < W && fruta_wy < H}, 32'd1);
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fruta_gen.md
Name: fruta_gen

Overview:
Fruit-position generator feeding the game update engine.
- On a `fruta_enable` request it draws pseudo-random map cells from an LFSR.
- It checks each candidate against the shared map memory through a dedicated read port.
- When it finds an empty cell, it returns that cell on `fruta_wx`/`fruta_wy` with a one-cycle `fruta_wenable` strobe.
- The consumer must hold off its fruit write until `fruta_wenable`.

Parameters:
- MAPA_WIDTH, 40, map columns.
- MAPA_HEIGHT, 30, map rows.
- LFSR_SEED, 16'hACE1, LFSR value after reset; must be nonzero.
- MAX_TRIES, 16, occupied random candidates tolerated before falling back to a raster scan.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fruta_enable  in  1  request pulse for a new fruit; ignored while busy.
- fruta_wenable  out  1  one-cycle strobe: `fruta_wx`/`fruta_wy` hold a new valid empty cell.
- fruta_wx  out  10  fruit column; held until the next success.
- fruta_wy  out  10  fruit row; held until the next success.
- fruta_fail  out  1  one-cycle strobe: map has no empty cell.
- busy  out  1  high from request acceptance until the result or fail strobe.
- gen_renable  out  1  map read request.
- gen_rx  out  10  map read column.
- gen_ry  out  10  map read row.
- gen_rdata  in  2  map cell contents, valid the cycle after `gen_renable`.

Behaviour:
- Reset values: all outputs 0; LFSR = LFSR_SEED; state = IDLE. Reset asserted mid-operation aborts with no strobe.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle in every state, so user timing adds entropy.
- Candidate derivation: XB = clog2(MAPA_WIDTH), YB = clog2(MAPA_HEIGHT). cand_x = lfsr[XB-1:0]; cand_y = lfsr[XB+YB-1:XB]; both zero-extended to 10 bits.
- IDLE: if fruta_enable, then tries = 0, busy = 1, go to DRAW.
- DRAW: if cand_x < MAPA_WIDTH and cand_y < MAPA_HEIGHT, register the candidate and go to READ. Otherwise stay in DRAW; a range rejection does not count as a try.
- READ: gen_renable = 1, gen_rx/gen_ry = candidate, go to CHECK. gen_renable is high for exactly one cycle per read.
- CHECK: evaluate gen_rdata.
  - gen_rdata == CELL_EMPTY: go to DONE.
  - Occupied and tries+1 == MAX_TRIES: scan_cnt = 0, start the scan at the next raster cell after the candidate, go to SCAN_READ.
  - Occupied otherwise: tries++, go to DRAW.
- SCAN_READ: issue a read at the scan cell, go to SCAN_CHECK.
- SCAN_CHECK: evaluate gen_rdata.
  - Empty: go to DONE.
  - Occupied: advance x; on x == MAPA_WIDTH-1 wrap x to 0 and y++; on y == MAPA_HEIGHT-1 wrap y to 0. scan_cnt++.
  - If scan_cnt reaches MAPA_WIDTH*MAPA_HEIGHT, pulse fruta_fail, busy = 0, go to IDLE (fruta_wx/wy unchanged). Otherwise go back to SCAN_READ.
- DONE: load fruta_wx/wy, pulse fruta_wenable, busy = 0, go to IDLE.
- Best-case latency: request sampled at cycle T → fruta_wenable high in cycle T+4.
- fruta_enable arriving in the DONE cycle is ignored; requests are not queued.
- The generator never writes the map; the consumer writes CELL_FRUIT.

Optional Feature:
Macro FRUTA_AVOID_BORDER_EN.
- Defined: DRAW accepts only 1 ≤ x ≤ MAPA_WIDTH-2 and 1 ≤ y ≤ MAPA_HEIGHT-2. The scan skips border cells without reading them. The scan limit becomes (MAPA_WIDTH-2)*(MAPA_HEIGHT-2).
- Undefined: the full map is eligible.

Decomposition:
- Package fruta_pkg:
  - cell codes CELL_EMPTY=0, CELL_SNAKE=1, CELL_FRUIT=2, CELL_OBST=3;
  - FSM state enum (IDLE, DRAW, READ, CHECK, SCAN_READ, SCAN_CHECK, DONE);
  - LFSR tap constant and default seed.
- One sub-module, fruta_lfsr: seedable 16-bit free-running LFSR with synchronous reset.

Test Plan:
1. Reset held 2 cycles → all outputs 0, no gen_renable; LFSR value equals 16'hACE1 after release.
2. Empty 40x30 map, fruta_enable pulse at T, first candidate in range → gen_renable at T+2 with candidate, fruta_wenable high only at T+4, fruta_wx < 40, fruta_wy < 30, equal to the read address.
3. Map full except (7,5), MAX_TRIES=4 → exactly 4 random CHECKs, then scan; single strobe with fruta_wx=7, fruta_wy=5.
4. Map fully occupied → fruta_fail single pulse after 4 + 1200 reads; fruta_wenable never set; fruta_wx/wy keep the previous value.
5. fruta_enable held high 20 cycles → exactly one result per IDLE acceptance; reset asserted during SCAN_READ → next cycle busy=0, gen_renable=0, no strobe.
6. Two runs, identical seed and request timing → identical coordinate sequences. With FRUTA_AVOID_BORDER_EN, 1000 requests on an empty map → no result with x∈{0,39} or y∈{0,29}.
